// File: rtl/leap_year_checker.sv
// Digit-serial BCD-to-binary year converter with leap-year verdict, valid/ready on both sides.
// Define LEAP_CENTURY_RULE_EN for the full Gregorian rule; otherwise the legacy divisible-by-4 rule is used.
module leap_year_checker #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   year_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      year_bin,
    output logic                  leap,
    output logic                  bcd_err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EVAL,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   shift_q, shift_d;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_int_q, err_int_d;
    logic                  out_valid_q, out_valid_d;
    logic [BIN_W-1:0]      year_bin_q, year_bin_d;
    logic                  leap_q, leap_d;
    logic                  bcd_err_q, bcd_err_d;

    logic                  err_any;
    logic                  leap_calc;
    logic [3:0]            top_nibble;

    always_comb begin
        err_any = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (year_bcd[4*i +: 4] > 4'd9) begin
                err_any = 1'b1;
            end
        end
    end

`ifdef LEAP_CENTURY_RULE_EN
    logic [31:0] year_ext;

    always_comb begin
        year_ext  = 32'(acc_q);
        leap_calc = ((((year_ext % 32'd4) == 32'd0) && ((year_ext % 32'd100) != 32'd0))
                     || ((year_ext % 32'd400) == 32'd0)) && !err_int_q;
    end
`else
    always_comb begin
        leap_calc = (acc_q[1:0] == 2'b00) && !err_int_q;
    end
`endif

    assign top_nibble = shift_q[4*DIGITS-1 -: 4];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_int_d   = err_int_q;
        out_valid_d = out_valid_q;
        year_bin_d  = year_bin_q;
        leap_d      = leap_q;
        bcd_err_d   = bcd_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = year_bcd;
                    acc_d     = '0;
                    err_int_d = err_any;
                    cnt_d     = CNT_W'(DIGITS - 1);
                    state_d   = CONV;
                end
            end
            CONV: begin
                // MSD first: multiply-accumulate, wrapping at BIN_W bits
                acc_d   = acc_q * BIN_W'(10) + BIN_W'(top_nibble);
                shift_d = shift_q << 4;
                if (cnt_q == '0) begin
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EVAL: begin
                year_bin_d  = acc_q;
                leap_d      = leap_calc;
                bcd_err_d   = err_int_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_int_q   <= 1'b0;
            out_valid_q <= 1'b0;
            year_bin_q  <= '0;
            leap_q      <= 1'b0;
            bcd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_int_q   <= err_int_d;
            out_valid_q <= out_valid_d;
            year_bin_q  <= year_bin_d;
            leap_q      <= leap_d;
            bcd_err_q   <= bcd_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign year_bin  = year_bin_q;
    assign leap      = leap_q;
    assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_leap_year_checker.sv
// Self-checking bench for leap_year_checker: directed corner years, hold/backpressure,
// mid-conversion reset and randomized years against an arithmetic reference model.
module tb_leap_year_checker;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] year_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [BIN_W-1:0]    year_bin;
    logic                leap;
    logic                bcd_err;

    int testCount = 0;
    int failCount = 0;

    leap_year_checker #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .year_bcd  (year_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .year_bin  (year_bin),
        .leap      (leap),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: decimal value of the digits, wrapped to BIN_W bits, plus calendar rule
    function automatic void refModel(input logic [15:0] bcd, output int yr, output bit lp, output bit er);
        int d;
        yr = 0;
        er = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) er = 1'b1;
            yr = (yr * 10 + d) % (1 << BIN_W);
        end
`ifdef LEAP_CENTURY_RULE_EN
        lp = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
`else
        lp = (yr % 4 == 0);
`endif
        lp = lp && !er;
    endfunction

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] bcd, input int holdCycles);
        int k;
        int yr;
        bit lp;
        bit er;
        logic [BIN_W-1:0] heldBin;
        logic             heldLeap;
        refModel(bcd, yr, lp, er);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        year_bcd = bcd;
        in_valid = 1'b1;
        stepClock();
        in_valid = 1'b0;
        year_bcd = 16'($urandom);
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            stepClock();
            k++;
        end
        checkOutput("latency", 32'(k), 32'd5);
        checkOutput("year_bin", 32'(year_bin), 32'(yr));
        checkOutput("leap", 32'(leap), 32'(lp));
        checkOutput("bcd_err", 32'(bcd_err), 32'(er));
        heldBin  = year_bin;
        heldLeap = leap;
        for (int h = 0; h < holdCycles; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            year_bcd  = 16'($urandom);
            stepClock();
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_year_bin", 32'(year_bin), 32'(heldBin));
            checkOutput("hold_leap", 32'(leap), 32'(heldLeap));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepClock();
        out_ready = 1'b0;
        checkOutput("release_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] rbcd;
        int          hold;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        year_bcd  = '0;
        stepClock();
        stepClock();
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_year_bin", 32'(year_bin), 32'd0);
        checkOutput("rst_leap", 32'(leap), 32'd0);
        checkOutput("rst_bcd_err", 32'(bcd_err), 32'd0);

        applyStimulus(16'h2024, 0);
        applyStimulus(16'h1900, 0);
        applyStimulus(16'h2000, 0);
        applyStimulus(16'h0000, 0);
        applyStimulus(16'h20A4, 0);
        applyStimulus(16'h9999, 0);
        applyStimulus(16'hFFFF, 0);
        applyStimulus(16'h2100, 0);
        applyStimulus(16'h2024, 10);
        applyStimulus(16'h1997, 0);

        year_bcd = 16'h1999;
        in_valid = 1'b1;
        stepClock();
        in_valid = 1'b0;
        stepClock();
        stepClock();
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_year_bin", 32'(year_bin), 32'd0);
        for (int i = 0; i < 6; i++) begin
            stepClock();
            checkOutput("abort_quiet", 32'(out_valid), 32'd0);
        end
        applyStimulus(16'h1996, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    rbcd[4*i +: 4] = 4'($urandom_range(10, 15));
                end else begin
                    rbcd[4*i +: 4] = 4'($urandom_range(0, 9));
                end
            end
            hold = int'($urandom_range(0, 3));
            applyStimulus(rbcd, hold);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
